// File: rtl/pipelined_barrel_shift.sv
// Pipelined rotate/logical/arithmetic shifter: one log2 mux level per stage, valid/ready on both sides.
// Optional macro BSHIFT_CARRY_EN adds a CarryOut port carrying the last bit shifted or wrapped out.
module pipelined_barrel_shift #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] In,
    input  logic [SHW-1:0]   Num,
    input  logic             LR,
    input  logic [1:0]       Mode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out
`ifdef BSHIFT_CARRY_EN
    ,
    output logic             CarryOut
`endif
);

    localparam logic [1:0] MODE_LOG = 2'b01;
    localparam logic [1:0] MODE_ARI = 2'b10;

    logic [SHW-1:0]   v_q, v_d;
    logic [WIDTH-1:0] data_q [SHW];
    logic [WIDTH-1:0] data_d [SHW];
    logic [SHW-1:0]   num_q  [SHW];
    logic [SHW-1:0]   num_d  [SHW];
    logic [1:0]       mode_q [SHW];
    logic [1:0]       mode_d [SHW];
    logic [SHW-1:0]   lr_q, lr_d;
    logic [SHW-1:0]   sign_q, sign_d;

    // load[k]: slot k is empty or its content moves on this cycle
    logic [SHW:0]     load;

    logic             src_v    [SHW+1];
    logic [WIDTH-1:0] src_data [SHW+1];
    logic [SHW-1:0]   src_num  [SHW+1];
    logic [1:0]       src_mode [SHW+1];
    logic             src_lr   [SHW+1];
    logic             src_sign [SHW+1];

`ifdef BSHIFT_CARRY_EN
    logic [SHW-1:0]   carry_q, carry_d;
    logic             src_carry [SHW+1];
`endif

    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input int               s,
        input logic             left,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic             rot;
        logic             fill;
        logic [SHW-1:0]   idx;
        logic [WIDTH-1:0] r;
        rot  = !((mode == MODE_LOG) || (mode == MODE_ARI));
        fill = (mode == MODE_ARI) && !left && sign;
        r    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // truncation to SHW bits wraps the source index modulo WIDTH
            if (left) begin
                idx = SHW'(i - s + WIDTH);
                r[i] = (i >= s || rot) ? d[idx] : 1'b0;
            end else begin
                idx = SHW'(i + s);
                r[i] = (i + s < WIDTH || rot) ? d[idx] : fill;
            end
        end
        return r;
    endfunction

`ifdef BSHIFT_CARRY_EN
    // Last bit leaving the word at this level; for rotates it is also the bit that wrapped.
    function automatic logic carry_level(
        input logic [WIDTH-1:0] d,
        input int               s,
        input logic             left
    );
        return left ? d[SHW'(WIDTH - s)] : d[SHW'(s - 1)];
    endfunction
`endif

    always_comb begin
        src_v[0]    = InValid;
        src_data[0] = In;
        src_num[0]  = Num;
        src_mode[0] = Mode;
        src_lr[0]   = LR;
        src_sign[0] = In[WIDTH-1];
`ifdef BSHIFT_CARRY_EN
        src_carry[0] = 1'b0;
`endif
        for (int k = 0; k < SHW; k++) begin
            src_v[k+1]    = v_q[k];
            src_data[k+1] = data_q[k];
            src_num[k+1]  = num_q[k];
            src_mode[k+1] = mode_q[k];
            src_lr[k+1]   = lr_q[k];
            src_sign[k+1] = sign_q[k];
`ifdef BSHIFT_CARRY_EN
            src_carry[k+1] = carry_q[k];
`endif
        end

        load[SHW] = OutReady;
        for (int k = SHW - 1; k >= 0; k--) begin
            load[k] = !v_q[k] || load[k+1];
        end

        v_d    = v_q;
        lr_d   = lr_q;
        sign_d = sign_q;
`ifdef BSHIFT_CARRY_EN
        carry_d = carry_q;
`endif
        for (int k = 0; k < SHW; k++) begin
            data_d[k] = data_q[k];
            num_d[k]  = num_q[k];
            mode_d[k] = mode_q[k];
            if (load[k]) begin
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    num_d[k]  = src_num[k];
                    mode_d[k] = src_mode[k];
                    lr_d[k]   = src_lr[k];
                    sign_d[k] = src_sign[k];
                    if (src_num[k][k]) begin
                        data_d[k] = shift_level(src_data[k], 1 << k, src_lr[k], src_mode[k], src_sign[k]);
                    end else begin
                        data_d[k] = src_data[k];
                    end
`ifdef BSHIFT_CARRY_EN
                    carry_d[k] = src_num[k][k] ? carry_level(src_data[k], 1 << k, src_lr[k]) : src_carry[k];
`endif
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            v_q    <= '0;
            lr_q   <= '0;
            sign_q <= '0;
`ifdef BSHIFT_CARRY_EN
            carry_q <= '0;
`endif
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                num_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            lr_q   <= lr_d;
            sign_q <= sign_d;
`ifdef BSHIFT_CARRY_EN
            carry_q <= carry_d;
`endif
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= data_d[k];
                num_q[k]  <= num_d[k];
                mode_q[k] <= mode_d[k];
            end
        end
    end

    assign InReady  = load[0];
    assign OutValid = v_q[SHW-1];
    assign Out      = data_q[SHW-1];
`ifdef BSHIFT_CARRY_EN
    assign CarryOut = carry_q[SHW-1];
`endif

endmodule

// File: doc/pipelined_barrel_shift.md
Name: pipelined_barrel_shift

Overview:
- Parametrised, pipelined successor to the 8-bit combinational rotator.
- Supports any power-of-two width and three modes: rotate, logical shift, and arithmetic shift.
- Registers one log2 mux level per pipeline stage.
- Uses valid/ready handshakes on both sides and sits between datapath producers and consumers that need backpressure-safe shifting at one result per cycle.

Parameters:
- WIDTH, 8, data width; must be a power of two and at least 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- Clk  input  1  rising-edge clock; sole clock domain.
- Rst  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
- InValid  input  1  In/Num/LR/Mode valid this cycle.
- InReady  output  1  block accepts when InValid && InReady.
- In  input  WIDTH  operand.
- Num  input  SHW  shift amount, 0..WIDTH-1.
- LR  input  1  direction: 0 = right, 1 = left.
- Mode  input  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved (behaves as rotate).
- OutValid  output  1  Out holds a result.
- OutReady  input  1  consumer accepts when OutValid && OutReady.
- Out  output  WIDTH  shifted result.

Behaviour:
- Pipeline structure:
  - SHW register stages, stage k = 0..SHW-1 (stage 0 nearest input).
  - Stage k shifts its data by 2^k in the captured direction/mode if captured Num bit k = 1, else passes it through.
  - LR, Mode, and remaining Num bits travel with the data.
- Per-stage shift rules (single level):
  - Rotate right by s: Out = {d[s-1:0], d[W-1:s]}.
  - Rotate left by s: Out = {d[W-s-1:0], d[W-1:W-s]}.
  - Logical: vacated bits are 0.
  - Arithmetic right: vacated bits copy d[W-1] of the original operand; sign is carried per stage, so the cascade is exact.
  - Arithmetic left: identical to logical left.
- Composite result equals a single shift by Num; Num = 0 passes In unchanged in all modes.
- Handshake and flow control:
  - Each stage has a valid bit.
  - Stage k advances when its downstream slot is empty or draining: adv[k] = !v[k+1] || adv[k+1]; the last stage drains when OutReady.
  - InReady = !v[0] || adv[0]; combinational path from OutReady to InReady is permitted.
  - Throughput: one transfer per cycle when OutReady is held high.
  - Latency: an operand accepted at edge t appears on Out with OutValid = 1 after edge t+SHW-1, i.e. SHW cycles after acceptance including the acceptance edge. For WIDTH = 8 the latency is 3.
  - Stalled stages hold data, Num, LR, and Mode stable; Out and OutValid must not change while OutValid && !OutReady.
  - Bubbles compress: an empty stage fills even when the output is stalled.
- Simultaneous events:
  - Accept and drain in the same cycle on a full pipe: both occur and occupancy is unchanged.
  - Inputs are ignored when InValid = 0 or InReady = 0.
- Reset:
  - While Rst = 1, at each rising edge of Clk: all valid bits cleared, Out = 0, OutValid = 0.
  - InReady = 1 on the first cycle after Rst deasserts.
  - Reset mid-operation drops all in-flight operands with no output produced.
  - Inputs presented in a cycle where Rst = 1 are not accepted.
- Out register: retains its last value after it is drained, until the next result is loaded.

Optional Feature:
- Macro: BSHIFT_CARRY_EN.
- Defined:
  - Adds output port CarryOut (1 bit), pipelined alongside Out.
  - For logical/arithmetic shifts, CarryOut = last bit shifted out: In[Num-1] for right, In[WIDTH-Num] for left.
  - CarryOut = 0 for Num = 0.
  - In rotate mode, CarryOut = the bit that wrapped last: Out[WIDTH-1] for right, Out[0] for left, 0 for Num = 0.
  - CarryOut resets to 0.
- Undefined: no CarryOut port and no added logic; all other behaviour identical.

Test Plan:
- WIDTH = 8, OutReady = 1. Send In = 8'hB1, Num = 3 in each mode, one per cycle. Required results:
  - rotate right 8'h36
  - rotate left 8'h8D
  - logical right 8'h16
  - logical left 8'h88
  - arithmetic right 8'hF6
  - Each result must appear exactly 3 cycles after acceptance, in order.
- Num = 0 sweep, all modes and both directions, In = 8'h5A -> Out = 8'h5A every time.
- Exhaustive: every In, Num 0..7, LR, and Mode 00-11, streamed back-to-back. Compare each result against the single-step reference loop; zero mismatches, one result per cycle.
- Backpressure: hold OutReady = 0 for 10 cycles while InValid = 1.
  - Exactly 3 operands accepted, then InReady = 0.
  - Out stays stable.
  - On release, results drain in order with no loss or duplication.
- Reset mid-flight: assert Rst for one cycle with 3 operands in flight -> OutValid = 0, Out = 8'h00 next cycle, none of the dropped results ever appear, and InReady = 1.
- BSHIFT_CARRY_EN defined, In = 8'hB1, Num = 3:
  - logical right -> CarryOut = 0
  - logical left -> CarryOut = 1
  - rotate right -> CarryOut = 0
  - Num = 0 -> CarryOut = 0
